// File: rtl/spike_synapse_driver.sv
// Spike-to-current synapse driver.
// Each accepted rising edge of spike_in adds a weight to a saturating 8-bit
// current. The current decays geometrically on every dt tick. A refractory
// window, an IDLE/REFRACT/DECAY state machine and a saturating spike counter
// complete the block.
module spike_synapse_driver #(
    parameter int REFRACT_CYCLES = 4,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   spike_in,
    input  logic [7:0]             weight,
    input  logic [2:0]             decay_shift,
    input  logic [7:0]             dt,
    input  logic                   clear_count,
    output logic [7:0]             current_out,
    output logic                   active,
    output logic [COUNT_WIDTH-1:0] spike_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REFRACT = 2'd1;
    localparam logic [1:0] S_DECAY   = 2'd2;

    localparam logic [7:0]             REFRACT_LOAD = 8'(REFRACT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX    = '1;

    logic [1:0]             r_state;
    logic [7:0]             r_tick_cnt;
    logic [7:0]             r_refr_cnt;
    logic                   r_spike_prev;
    logic [7:0]             r_current;
    logic                   r_active;
    logic [COUNT_WIDTH-1:0] r_count;

    logic                   w_event;
    logic                   w_accept;
    logic                   w_tick;
    logic [7:0]             w_current_nxt;
    logic [1:0]             w_state_nxt;
    logic [7:0]             w_refr_nxt;

    // Add the weight, clamping at full scale via a 9-bit intermediate.
    function automatic logic [7:0] sat_add(input logic [7:0] cur, input logic [7:0] w);
        logic [8:0] sum;
        sum = {1'b0, cur} + {1'b0, w};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // One geometric decay step; a minimum step of 1 guarantees reaching 0.
    function automatic logic [7:0] decay_step(input logic [7:0] cur, input logic [2:0] sh);
        logic [7:0] d;
        d = cur >> sh;
        if (d == 8'd0 && cur != 8'd0) begin
            d = 8'd1;
        end
        return cur - d;
    endfunction

    assign w_event  = spike_in & ~r_spike_prev;
    assign w_accept = w_event & (r_state != S_REFRACT);
    assign w_tick   = (r_tick_cnt >= dt);

    // Next current: an accepted event takes precedence over a decay tick.
    always_comb begin
        w_current_nxt = r_current;
        if (w_accept) begin
            w_current_nxt = sat_add(r_current, weight);
        end else if (w_tick) begin
            w_current_nxt = decay_step(r_current, decay_shift);
        end
    end

    // Next state and refractory counter.
    always_comb begin
        w_state_nxt = r_state;
        w_refr_nxt  = r_refr_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_REFRACT;
                    w_refr_nxt  = REFRACT_LOAD;
                end
            end
            S_REFRACT: begin
                if (r_refr_cnt == 8'd0) begin
                    w_state_nxt = (w_current_nxt != 8'd0) ? S_DECAY : S_IDLE;
                end else begin
                    w_refr_nxt = r_refr_cnt - 8'd1;
                end
            end
            S_DECAY: begin
                if (w_accept) begin
                    w_state_nxt = S_REFRACT;
                    w_refr_nxt  = REFRACT_LOAD;
                end else if (w_current_nxt == 8'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Edge detector history and the free-running dt tick counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_spike_prev <= 1'b0;
            r_tick_cnt   <= 8'd0;
        end else begin
            r_spike_prev <= spike_in;
            r_tick_cnt   <= w_tick ? 8'd0 : r_tick_cnt + 8'd1;
        end
    end

    // Current accumulator, state machine and registered active flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_current  <= 8'd0;
            r_state    <= S_IDLE;
            r_refr_cnt <= 8'd0;
            r_active   <= 1'b0;
        end else begin
            r_current  <= w_current_nxt;
            r_state    <= w_state_nxt;
            r_refr_cnt <= w_refr_nxt;
            r_active   <= (w_state_nxt != S_IDLE);
        end
    end

    // Saturating accepted-spike counter; clear wins over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear_count) begin
            r_count <= '0;
        end else if (w_accept && r_count != COUNT_MAX) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign current_out = r_current;
    assign active      = r_active;
    assign spike_count = r_count;

endmodule

// File: tb/tb_spike_synapse_driver.sv
// Scoreboard bench for spike_synapse_driver: a behavioural model predicts the
// outputs after every clock edge, a monitor compares them against the DUT.
module tb_spike_synapse_driver;

    localparam int R  = 4;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          spike_in = 1'b0;
    logic [7:0]    weight = 8'd0;
    logic [2:0]    decay_shift = 3'd0;
    logic [7:0]    dt = 8'd0;
    logic          clear_count = 1'b0;
    logic [7:0]    current_out;
    logic          active;
    logic [CW-1:0] spike_count;

    spike_synapse_driver #(.REFRACT_CYCLES(R), .COUNT_WIDTH(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .spike_in    (spike_in),
        .weight      (weight),
        .decay_shift (decay_shift),
        .dt          (dt),
        .clear_count (clear_count),
        .current_out (current_out),
        .active      (active),
        .spike_count (spike_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cur;
        int act;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    int m_cur, m_cnt, m_prev, m_since_tick, m_edge, m_last_acc, m_has_acc;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        m_cur = 0; m_cnt = 0; m_prev = 0; m_since_tick = 0;
        m_edge = 0; m_last_acc = 0; m_has_acc = 0;
    endfunction

    // Predict outputs after the coming edge from the current inputs.
    function automatic exp_t model_step();
        exp_t e;
        int ev, refr, acc, tick, d;
        ev   = (spike_in == 1'b1 && m_prev == 0) ? 1 : 0;
        m_prev = int'(spike_in);
        refr = (m_has_acc != 0 && m_edge - m_last_acc >= 1 && m_edge - m_last_acc <= R) ? 1 : 0;
        acc  = ev && !refr;
        tick = (m_since_tick >= int'(dt)) ? 1 : 0;
        m_since_tick = tick ? 0 : m_since_tick + 1;
        if (acc) begin
            m_cur = m_cur + int'(weight);
            if (m_cur > 255) m_cur = 255;
            m_last_acc = m_edge;
            m_has_acc = 1;
        end else if (tick) begin
            d = m_cur / (1 << decay_shift);
            if (d == 0 && m_cur != 0) d = 1;
            m_cur = m_cur - d;
        end
        if (clear_count) m_cnt = 0;
        else if (acc && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        m_edge++;
        e.cur = m_cur;
        e.cnt = m_cnt;
        e.act = (m_cur != 0 || (m_has_acc != 0 && m_edge - m_last_acc <= R)) ? 1 : 0;
        return e;
    endfunction

    task automatic cyc(input logic sp, input logic clr);
        spike_in = sp;
        clear_count = clr;
        q.push_back(model_step());
        @(posedge clock);
        #2;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        spike_in = 1'b0;
        clear_count = 1'b0;
        #1;
        chk("rst_current", int'(current_out), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_count", int'(spike_count), 0);
        model_reset();
        q.delete();
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued prediction each edge.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (reset) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty no prediction queued t=%0t", $time);
            end else begin
                e = q.pop_front();
                chk("current_out", int'(current_out), e.cur);
                chk("active", int'(active), e.act);
                chk("spike_count", int'(spike_count), e.cnt);
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clock);
        #2;

        // Single spike, per-clock decay with shift 2
        do_reset();
        weight = 8'd100; dt = 8'd0; decay_shift = 3'd2;
        cyc(1'b1, 1'b0);
        repeat (40) cyc(1'b0, 1'b0);

        // Held-high spike gives a single event
        do_reset();
        weight = 8'd50; dt = 8'd255; decay_shift = 3'd1;
        repeat (20) cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0);

        // Saturation with two large spikes
        do_reset();
        weight = 8'd200; dt = 8'd255;
        cyc(1'b1, 1'b0);
        repeat (9) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);

        // Refractory window: clocks 0 and 6 accepted, clock 2 dropped
        do_reset();
        weight = 8'd10; dt = 8'd255;
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);

        // Ticked decay from 80 with dt=3, shift 1
        do_reset();
        weight = 8'd80; dt = 8'd3; decay_shift = 3'd1;
        cyc(1'b1, 1'b0);
        repeat (40) cyc(1'b0, 1'b0);

        // Weight-0 event and clear coinciding with a spike
        weight = 8'd0;
        cyc(1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b0);
        weight = 8'd30;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);

        // Decay shift 0 clears on the next tick
        decay_shift = 3'd0; dt = 8'd0;
        repeat (6) cyc(1'b0, 1'b0);

        // Async reset in DECAY with current 120
        do_reset();
        weight = 8'd120; dt = 8'd255; decay_shift = 3'd1;
        cyc(1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b0);
        do_reset();
        repeat (2) cyc(1'b0, 1'b0);

        // Counter saturation: an accepted spike every 6 clocks
        weight = 8'd3; dt = 8'd1; decay_shift = 3'd2;
        for (int i = 0; i < 1800; i++) cyc((i % 6) == 0, 1'b0);
        cyc(1'b0, 1'b1);

        // Randomised traffic with occasional parameter changes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                weight      = 8'($urandom_range(0, 255));
                decay_shift = 3'($urandom_range(0, 7));
                dt          = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(0, 12));
            end
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 149) == 0));
        end

        // Let the monitor consume the last prediction
        #5;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover actual=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
